// File: rtl/reorder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_pkg
//  Brief    : Shared types and helpers for the reorder ingress stage.
//             The write-beat struct depends on the DW/AW parameters of the
//             instantiating module, so it is declared in reorder_ingress.
//  Revision : 1.0  initial release
// ============================================================================
package reorder_pkg;

    // Per-bank lifecycle: accepting beats, full and awaiting FIFO, draining.
    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SEALED = 2'd1,
        DRAIN  = 2'd2
    } bank_state_e;

    // Number of slots in one bank for a given offset width.
    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_bank_trk.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_bank_trk
//  Brief    : Fill tracker for one reorder bank. It holds the bank FSM, the
//             slot-written bitmap and fill count, and qualifies each offered
//             beat as a new write or a duplicate.
//  Revision : 1.0  initial release
// ============================================================================
module reorder_bank_trk
    import reorder_pkg::*;
#(
    parameter int AW = 7
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sel,       // current beat targets this bank
    input  logic          in_vld,
    input  logic [AW-1:0] off,
    input  logic          full,
    input  logic          empty,
    output logic          rdy,
    output logic          acc_new,
    output logic          acc_dup,
    output logic          seal
);

    localparam int          DEPTH  = depth_of(AW);
    localparam logic [AW:0] c_LAST = (AW+1)'(DEPTH - 1);

    bank_state_e      r_state;
    bank_state_e      w_state_nxt;
    logic [AW:0]      r_cnt;
    logic [DEPTH-1:0] r_bitmap;
    logic             w_acc;
    logic             w_clear;

    // A full FIFO while filling should not happen; holding rdy low keeps
    // the bank safe if it does.
    assign rdy     = (r_state == FILL) && !full;
    assign w_acc   = sel && in_vld && rdy;
    assign acc_new = w_acc && !r_bitmap[off];
    assign acc_dup = w_acc &&  r_bitmap[off];
    assign seal    = (r_state != FILL);
    assign w_clear = (r_state == DRAIN) && empty;

    // Bank state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: seal on the last new slot, drain once the FIFO reports
    // full, reopen only once it reports empty while draining.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL: begin
                if (acc_new && (r_cnt == c_LAST)) begin
                    w_state_nxt = SEALED;
                end
            end
            SEALED: begin
                if (full) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (empty) begin
                    w_state_nxt = FILL;
                end
            end
            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    // Fill count and written-slot bitmap; both clear when the bank reopens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_bitmap <= '0;
        end else if (w_clear) begin
            r_cnt    <= '0;
            r_bitmap <= '0;
        end else if (acc_new) begin
            r_cnt         <= r_cnt + {{AW{1'b0}}, 1'b1};
            r_bitmap[off] <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reorder_ingress.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_ingress
//  Brief    : Steers an out-of-order tagged response stream into two
//             ping-pong reorder FIFOs. Tag MSB selects the bank, the low
//             tag bits give the write offset. Duplicate tags are dropped
//             and flagged.
//  Revision : 1.0  initial release
// ============================================================================
module reorder_ingress
    import reorder_pkg::*;
#(
    parameter int DW = 18,
    parameter int AW = 7
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [DW-1:0] in_data,
    input  logic [AW:0]   in_seq,      // tag: bit AW = bank, AW-1:0 = offset
    output logic          push0,
    output logic          push1,
    output logic [DW-1:0] data_in,
    output logic [AW-1:0] data_offset,
    input  logic          full0,
    input  logic          full1,
    input  logic          empty0,
    input  logic          empty1,
    output logic          dup_err,
    output logic [1:0]    seal
);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] offset;
    } beat_t;

    logic          w_bank;
    logic [AW-1:0] w_off;
    logic [1:0]    w_full;
    logic [1:0]    w_empty;
    logic [1:0]    w_sel;
    logic [1:0]    w_rdy;
    logic [1:0]    w_new;
    logic [1:0]    w_dup;
    logic [1:0]    w_seal;
    beat_t         r_beat;

    assign w_bank  = in_seq[AW];
    assign w_off   = in_seq[AW-1:0];
    assign w_full  = {full1, full0};
    assign w_empty = {empty1, empty0};

    // Ready follows the bank the current tag points at, so it is
    // combinational on in_seq.
    assign in_rdy = w_rdy[w_bank];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign w_sel[b] = (w_bank == 1'(b));

        reorder_bank_trk #(
            .AW (AW)
        ) u_trk (
            .clk     (clk),
            .rst_n   (rst_n),
            .sel     (w_sel[b]),
            .in_vld  (in_vld),
            .off     (w_off),
            .full    (w_full[b]),
            .empty   (w_empty[b]),
            .rdy     (w_rdy[b]),
            .acc_new (w_new[b]),
            .acc_dup (w_dup[b]),
            .seal    (w_seal[b])
        );
    end

    assign seal        = w_seal;
    assign data_in     = r_beat.data;
    assign data_offset = r_beat.offset;

    // One-cycle write pipeline: push strobes, duplicate flag and the beat
    // captured on a new accept. Only one bank can accept per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push0   <= 1'b0;
            push1   <= 1'b0;
            dup_err <= 1'b0;
            r_beat  <= '0;
        end else begin
            push0   <= w_new[0];
            push1   <= w_new[1];
            dup_err <= |w_dup;
            if (|w_new) begin
                r_beat.data   <= in_data;
                r_beat.offset <= w_off;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_ingress.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reorder_ingress
//  Brief    : Self-checking bench for reorder_ingress (AW=2, DEPTH=4):
//             directed scenarios with literal expectations plus a random
//             run checked every cycle against a slot-set bank model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reorder_ingress;

    localparam int DW    = 18;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] in_data = '0;
    logic [AW:0]   in_seq = '0;
    logic          push0, push1;
    logic [DW-1:0] data_in;
    logic [AW-1:0] data_offset;
    logic          full0 = 1'b0, full1 = 1'b0, empty0 = 1'b0, empty1 = 1'b0;
    logic          dup_err;
    logic [1:0]    seal;

    reorder_ingress #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
        .in_data(in_data), .in_seq(in_seq), .push0(push0), .push1(push1),
        .data_in(data_in), .data_offset(data_offset), .full0(full0),
        .full1(full1), .empty0(empty0), .empty1(empty1), .dup_err(dup_err),
        .seal(seal)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;

    // Model: bank phase (0 open, 1 complete awaiting FIFO full, 2 draining)
    // and the set of offsets already written in each bank.
    int            m_phase[2];
    bit            m_written[2][DEPTH];
    bit            e_push0, e_push1, e_dup;
    logic [DW-1:0] e_data;
    logic [AW-1:0] e_off;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int slots_used(input int b);
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_written[b][i]);
        return n;
    endfunction

    function automatic bit m_rdy();
        int b = int'(in_seq[AW]);
        bit f = (b == 1) ? full1 : full0;
        return (m_phase[b] == 0) && !f;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0;
            for (int i = 0; i < DEPTH; i++) m_written[k][i] = 1'b0;
        end
        e_push0 = 0; e_push1 = 0; e_dup = 0; e_data = '0; e_off = '0;
    endtask

    // Apply one clock edge to the model using the inputs present at the edge.
    task automatic m_step();
        int b   = int'(in_seq[AW]);
        int o   = int'(in_seq[AW-1:0]);
        bit acc = in_vld && m_rdy();
        bit fv[2];
        bit ev[2];
        bit fresh;
        fv[0] = full0;  fv[1] = full1;
        ev[0] = empty0; ev[1] = empty1;
        fresh   = acc && !m_written[b][o];
        e_push0 = fresh && (b == 0);
        e_push1 = fresh && (b == 1);
        e_dup   = acc && m_written[b][o];
        if (fresh) begin
            e_data = in_data;
            e_off  = o[AW-1:0];
        end
        for (int k = 0; k < 2; k++) begin
            if (m_phase[k] == 0) begin
                if (fresh && k == b) begin
                    m_written[k][o] = 1'b1;
                    if (slots_used(k) == DEPTH) m_phase[k] = 1;
                end
            end else if (m_phase[k] == 1) begin
                if (fv[k]) m_phase[k] = 2;
            end else begin
                if (ev[k]) begin
                    m_phase[k] = 0;
                    for (int i = 0; i < DEPTH; i++) m_written[k][i] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("push0", push0, e_push0);
        chk("push1", push1, e_push1);
        chk("dup_err", dup_err, e_dup);
        chk("seal", seal, {30'd0, m_phase[1] != 0, m_phase[0] != 0});
        if (e_push0 || e_push1) begin
            chk("data_in", data_in, e_data);
            chk("data_offset", data_offset, e_off);
        end
    endtask

    task automatic cycle(input bit v, input logic [AW:0] s, input logic [DW-1:0] d,
                         input bit f0, input bit f1, input bit e0, input bit e1);
        in_vld = v; in_seq = s; in_data = d;
        full0 = f0; full1 = f1; empty0 = e0; empty1 = e1;
        #1;
        chk("in_rdy", in_rdy, m_rdy());
        @(posedge clk);
        m_step();
        #1;
        check_all();
        n_vec++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, 0, 0, 0);
    endtask

    // Async reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        in_vld = 0; full0 = 0; full1 = 0; empty0 = 0; empty1 = 0;
        #1;
        m_reset();
        chk("rst_push0", push0, 0);
        chk("rst_push1", push1, 0);
        chk("rst_seal", seal, 0);
        chk("rst_dup", dup_err, 0);
        chk("rst_offset", data_offset, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        m_reset();
        #12;
        do_reset();

        // Out-of-order fill of bank 0: offsets 3,1,0,2, then sealed.
        cycle(1, 3'd3, 18'h111, 0, 0, 0, 0);
        chk("t1_push0_a", push0, 1); chk("t1_off_a", data_offset, 3); chk("t1_data_a", data_in, 18'h111);
        cycle(1, 3'd1, 18'h222, 0, 0, 0, 0);
        chk("t1_push0_b", push0, 1); chk("t1_off_b", data_offset, 1);
        cycle(1, 3'd0, 18'h333, 0, 0, 0, 0);
        chk("t1_off_c", data_offset, 0);
        cycle(1, 3'd2, 18'h044, 0, 0, 0, 0);
        chk("t1_off_d", data_offset, 2); chk("t1_seal", seal, 2'b01);
        cycle(1, 3'd1, 18'h055, 0, 0, 0, 0);
        chk("t1_sealed_nopush", push0, 0);

        // Bank 0 drains while bank 1 fills; then bank 0 reopens.
        cycle(0, 3'd0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 3'(4 + i), 18'(i + 5), 1, 0, 0, 0);
            chk("t2_push1", push1, 1);
            chk("t2_push0", push0, 0);
            chk("t2_off", data_offset, i);
        end
        chk("t2_seal_both", seal, 2'b11);
        cycle(0, 3'd0, 0, 0, 0, 1, 0);
        chk("t2_reopen_seal", seal, 2'b10);
        cycle(1, 3'd0, 18'h3abcd, 0, 0, 0, 0);
        chk("t2_reaccept", push0, 1);

        // Duplicate tag: one push, one dup pulse.
        do_reset();
        cycle(1, 3'd1, 18'h1, 0, 0, 0, 0);
        chk("t3_first_push", push0, 1);
        cycle(1, 3'd1, 18'h2, 0, 0, 0, 0);
        chk("t3_dup_push", push0, 0); chk("t3_dup_err", dup_err, 1);
        cycle(0, 3'd0, 0, 0, 0, 0, 0);
        chk("t3_dup_once", dup_err, 0);

        // Sealed bank ignores empty until full has been seen.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 3'(i), 18'(i), 0, 0, 0, 0);
        idle(5);
        cycle(0, 3'd0, 0, 0, 0, 1, 0);
        chk("t4_hold_seal", seal, 2'b01);
        cycle(1, 3'd2, 0, 0, 0, 0, 0);
        chk("t4_hold_nopush", push0, 0);

        // Reset mid-fill, then a clean refill with no duplicates.
        do_reset();
        cycle(1, 3'd0, 18'h7, 0, 0, 0, 0);
        cycle(1, 3'd1, 18'h8, 0, 0, 0, 0);
        chk("t5_pre_rst_push0", push0, 1);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, 3'(i), 18'(i + 9), 0, 0, 0, 0);
            chk("t5_push0", push0, 1);
            chk("t5_nodup", dup_err, 0);
        end

        // Alternating banks.
        do_reset();
        cycle(1, 3'd0, 0, 0, 0, 0, 0); chk("t6_p0a", {push1, push0}, 2'b01); chk("t6_oa", data_offset, 0);
        cycle(1, 3'd4, 0, 0, 0, 0, 0); chk("t6_p1a", {push1, push0}, 2'b10); chk("t6_ob", data_offset, 0);
        cycle(1, 3'd1, 0, 0, 0, 0, 0); chk("t6_p0b", {push1, push0}, 2'b01); chk("t6_oc", data_offset, 1);
        cycle(1, 3'd5, 0, 0, 0, 0, 0); chk("t6_p1b", {push1, push0}, 2'b10); chk("t6_od", data_offset, 1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 4) != 0, 3'($urandom), 18'($urandom),
                  ($urandom % 12) == 0, ($urandom % 12) == 0,
                  ($urandom % 8) == 0,  ($urandom % 8) == 0);
            chk("never_both_push", push0 & push1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reorder_ingress.md
Name: reorder_ingress

Overview:
- Upstream stage feeding a pair of reorder FIFOs (bank 0 / bank 1) in a ping-pong arrangement.
- Accepts an out-of-order response stream tagged with a sequence number.
- Steers each beat to the bank selected by the sequence MSB, at offset = low sequence bits.
- Tracks per-bank fill, seals a bank once all DEPTH slots are written, reopens it after the FIFO has fully drained, and drops/flags duplicate tags.

Parameters:
DW, 18, payload width (matches FIFO data width)
AW, 7, FIFO offset width; DEPTH = 2**AW entries per bank
SW, AW+1 (localparam), sequence tag width: bit AW = bank select, bits AW-1:0 = offset

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_vld  in  1  upstream beat valid
in_rdy  out  1  upstream beat ready (combinational)
in_data  in  DW  payload
in_seq  in  SW  sequence tag
push0  out  1  push to bank-0 FIFO (registered)
push1  out  1  push to bank-1 FIFO (registered)
data_in  out  DW  payload to both FIFOs (registered)
data_offset  out  AW  write offset to both FIFOs (registered)
full0  in  1  bank-0 FIFO full
full1  in  1  bank-1 FIFO full
empty0  in  1  bank-0 FIFO empty
empty1  in  1  bank-1 FIFO empty
dup_err  out  1  one-cycle pulse: duplicate tag dropped
seal  out  2  per-bank sealed status (bank done filling, awaiting drain)

Behaviour:
- Reset and clocking: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: push0/push1 = 0, data_in = 0, data_offset = 0, dup_err = 0, seal = 2'b00, both bank FSMs = FILL, counts = 0, bitmaps = 0.
- bank b = in_seq[AW]; off = in_seq[AW-1:0].
- in_rdy = (state[b] == FILL) && !full_b. It depends combinationally on in_seq by design.
- Accept = in_vld && in_rdy.
- On accept with bitmap[b][off] == 0: set the bit, increment cnt[b] (width AW+1).
- On the next cycle: push_b = 1, data_in = in_data, data_offset = off. Latency is exactly 1 clk.
- On accept with bitmap[b][off] == 1: no push; dup_err = 1 next cycle; cnt unchanged. The beat counts as consumed.
- push0 and push1 are never both high. At most one accept occurs per cycle.
- Per-bank FSM (b = 0, 1):
  - FILL -> SEALED when an accept makes cnt[b] == DEPTH. seal[b] = 1 from the next cycle.
  - SEALED -> DRAIN when full_b == 1 (FIFO has registered the last write). No accepts to bank b in SEALED or DRAIN.
  - DRAIN -> FILL when empty_b == 1. On this transition: cnt[b] = 0, bitmap[b] = 0, seal[b] = 0.
  - A beat for bank b is accepted again on the cycle after the return to FILL.
- The two banks are independent. Bank 0 can FILL while bank 1 is in DRAIN; that is the double-buffer case.
- Boundary conditions:
  - Final (DEPTH-th) write: accepted normally. in_rdy for that bank falls the following cycle.
  - full_b asserted while in FILL (should not occur): in_rdy is held low and state is unchanged.
  - empty_b already high on entry to DRAIN is not possible: full_b was seen first. Only empty_b seen in DRAIN reopens the bank.
  - Duplicate tag to a SEALED bank: not accepted (in_rdy = 0). No dup_err.
  - Reset mid-operation: all state clears immediately (async). Pushes in flight are discarded. The FIFOs are reset by the same rst_n.

Decomposition:
- Package reorder_pkg holds:
  - typedef enum logic [1:0] {FILL, SEALED, DRAIN} bank_state_e;
  - localparam DEPTH function of AW.
  - typedef struct {data, offset} for the write beat.
- One sub-module is natural: reorder_bank_trk (one instance per bank). It contains the FSM, cnt, bitmap, seal, and the dup/accept qualification.
- The top instantiates two reorder_bank_trk plus the steering and output registers.

Test Plan:
- AW=2 (DEPTH 4). Tags 3,1,0,2 with in_vld held -> push0 pulses with offsets 3,1,0,2, each 1 clk after accept. seal[0] = 1 after the 4th. in_rdy = 0 for subsequent bank-0 tags.
- Tag 1, then tag 1 again -> one push0 only. dup_err pulses once, the cycle after the 2nd accept. cnt[0] stays 1.
- Fill bank 0 (tags 0..3), drive full0 = 1, then tags 4..7 -> push1 for offsets 0..3 while bank 0 is in DRAIN. Then empty0 = 1 -> seal[0] = 0 and tag 0 accepted the next cycle.
- Bank 0 sealed, no full0 yet -> state holds SEALED indefinitely. empty0 pulse while in SEALED is ignored.
- Assert rst_n = 0 mid-fill (cnt[0] = 2) -> push0 = 0 and seal = 0 immediately, with no clock edge. After release, tags 0..3 accepted without dup_err.
- Back-to-back alternating tags 0,4,1,5 -> push0/push1 alternate, never both high. data_offset follows 0,0,1,1.
